sequence_timer_ctrl: RTL and testbench



---
 rtl/sequence_timer_ctrl.sv | 111 +++++++++++
 tb/tb_sequence_timer_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sequence_timer_ctrl.sv
// sequence_timer_ctrl: generates the registered select code and enable for a 4-to-16 timing decoder,
// with single-shot or wrapping runs, hold/pause and abort.
module sequence_timer_ctrl #(
   parameter logic [3:0] DEFAULT_LAST = 4'd15
) (
   input  logic       i_clock,
   input  logic       i_reset_b,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic       i_hold,
   input  logic       i_continuous,
   input  logic [3:0] i_last,
   input  logic       i_last_valid,
   output logic [3:0] o_count,
   output logic       o_dec_en,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_wrap
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

   state_t     r_state;
   logic [3:0] r_count;
   logic [3:0] r_last;
   logic       r_cont;
   logic       r_dec_en;
   logic       r_busy;
   logic       r_done;
   logic       r_wrap;

   always_ff @(posedge i_clock or negedge i_reset_b) begin
      if (!i_reset_b) begin
         r_state  <= IDLE;
         r_count  <= 4'd0;
         r_last   <= DEFAULT_LAST;
         r_cont   <= 1'b0;
         r_dec_en <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_wrap <= 1'b0;
         case (r_state)
            IDLE: begin
               r_count <= 4'd0;
               if (!i_stop && i_start) begin
                  r_last   <= i_last_valid ? i_last : DEFAULT_LAST;
                  r_cont   <= i_continuous;
                  r_state  <= RUN;
                  r_dec_en <= 1'b1;
                  r_busy   <= 1'b1;
               end else begin
                  r_dec_en <= 1'b0;
                  r_busy   <= 1'b0;
               end
            end
            RUN: begin
               if (i_stop) begin
                  r_state  <= IDLE;
                  r_count  <= 4'd0;
                  r_dec_en <= 1'b0;
                  r_busy   <= 1'b0;
               end else if (i_hold) begin
                  r_state  <= PAUSE;
                  r_dec_en <= 1'b0;
               end else if (r_count != r_last) begin
                  r_count <= r_count + 4'd1;
               end else if (r_cont) begin
                  r_count <= 4'd0;
                  r_wrap  <= 1'b1;
               end else begin
                  r_state  <= DONE;
                  r_dec_en <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end
            end
            PAUSE: begin
               if (i_stop) begin
                  r_state <= IDLE;
                  r_count <= 4'd0;
                  r_busy  <= 1'b0;
               end else if (!i_hold) begin
                  // Re-present the interrupted T state before advancing again
                  r_state  <= RUN;
                  r_dec_en <= 1'b1;
               end
            end
            DONE: begin
               r_state  <= IDLE;
               r_count  <= 4'd0;
               r_dec_en <= 1'b0;
               r_busy   <= 1'b0;
            end
            default: begin
               r_state  <= IDLE;
               r_count  <= 4'd0;
               r_dec_en <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign o_count  = r_count;
   assign o_dec_en = r_dec_en;
   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_wrap   = r_wrap;
endmodule

// File: tb/tb_sequence_timer_ctrl.sv
// tb_sequence_timer_ctrl: scoreboard bench; an advance-counting reference model predicts each cycle's outputs.
module tb_sequence_timer_ctrl;
   typedef struct packed {
      logic [3:0] count;
      logic       en;
      logic       busy;
      logic       done;
      logic       wrap;
   } out_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, hold = 1'b0, cont = 1'b0, lv = 1'b0;
   logic [3:0] last = 4'd0;
   logic [3:0] o_count;
   logic       o_dec_en, o_busy, o_done, o_wrap;

   int   checks = 0;
   int   errors = 0;
   out_t sb[$];

   // Model: a run is a number of advances p; the T index is p mod (L+1)
   bit m_active, m_paused, m_donec, m_done, m_wrap;
   int m_L, m_p;
   bit m_C;

   sequence_timer_ctrl dut (
      .i_clock(clk), .i_reset_b(rst_n), .i_start(start), .i_stop(stop), .i_hold(hold),
      .i_continuous(cont), .i_last(last), .i_last_valid(lv),
      .o_count(o_count), .o_dec_en(o_dec_en), .o_busy(o_busy), .o_done(o_done), .o_wrap(o_wrap)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         out_t e, a;
         e = sb.pop_front();
         a = {o_count, o_dec_en, o_busy, o_done, o_wrap};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t: got count=%0d en=%b busy=%b done=%b wrap=%b, expected count=%0d en=%b busy=%b done=%b wrap=%b",
                     $time, a.count, a.en, a.busy, a.done, a.wrap, e.count, e.en, e.busy, e.done, e.wrap);
         end
      end
   end

   task automatic m_reset();
      m_active = 0; m_paused = 0; m_donec = 0; m_done = 0; m_wrap = 0;
      m_L = 15; m_C = 0; m_p = 0;
   endtask

   task automatic model_step();
      m_done = 0;
      m_wrap = 0;
      if (m_donec) m_donec = 0;
      else if (!m_active) begin
         if (!stop && start) begin
            m_active = 1; m_paused = 0; m_p = 0;
            m_L = lv ? int'(last) : 15;
            m_C = cont;
         end
      end else if (stop) begin
         m_active = 0; m_paused = 0;
      end else if (m_paused) begin
         if (!hold) m_paused = 0;
      end else if (hold) m_paused = 1;
      else begin
         m_p++;
         if (!m_C && m_p == m_L + 1) begin
            m_active = 0; m_donec = 1; m_done = 1;
         end else if (m_C && m_p % (m_L + 1) == 0) m_wrap = 1;
      end
   endtask

   function automatic out_t m_out();
      out_t e;
      e.count = m_donec ? 4'(m_L) : (m_active ? 4'(m_p % (m_L + 1)) : 4'd0);
      e.en    = m_active && !m_paused;
      e.busy  = m_active;
      e.done  = m_done;
      e.wrap  = m_wrap;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst_n) m_reset();
      else model_step();
      sb.push_back(m_out());
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_in(input bit s, input bit sp, input bit h, input bit c, input int l, input bit v);
      start = s; stop = sp; hold = h; cont = c; last = 4'(l); lv = v;
   endtask

   task automatic launch(input int l, input bit v, input bit c);
      set_in(1, 0, 0, c, l, v);
      tick();
      start = 0;
   endtask

   task automatic reset_mid();
      #1 rst_n = 0;
      #1;
      checks++;
      if (o_count !== 4'd0 || o_dec_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_wrap !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got count=%0d en=%b busy=%b, expected count=0 en=0 busy=0",
                  o_count, o_dec_en, o_busy);
      end
      m_reset();
      void'(sb.pop_back());
      sb.push_back(m_out());
      tick();
      rst_n = 1;
   endtask

   initial begin
      m_reset();
      ticks(3);
      rst_n = 1;
      ticks(2);
      // single-shot Last=5
      launch(5, 1, 0);
      ticks(9);
      // continuous default terminal count, then abort
      launch(9, 0, 1);
      ticks(40);
      stop = 1; tick(); stop = 0;
      ticks(2);
      // hold at Count=3 for 4 cycles, then resume
      launch(7, 1, 0);
      ticks(3);
      hold = 1; ticks(4); hold = 0;
      ticks(8);
      // hold and stop together
      launch(7, 1, 0);
      ticks(2);
      hold = 1; stop = 1; tick(); hold = 0; stop = 0;
      ticks(2);
      // Last=0 single-shot
      launch(0, 1, 0);
      ticks(4);
      // start with stop in idle
      set_in(1, 1, 0, 0, 3, 1); tick(); set_in(0, 0, 0, 0, 3, 1);
      ticks(2);
      // start held high across the DONE cycle
      set_in(1, 0, 0, 0, 2, 1);
      ticks(10);
      start = 0;
      ticks(5);
      // reset mid-run at Count=4
      launch(7, 1, 0);
      ticks(4);
      reset_mid();
      ticks(3);
      // every terminal count, with mid-run input churn
      for (int l = 0; l < 16; l++) begin
         launch(l, 1, 0);
         last = 4'($urandom); cont = 1'($urandom); lv = 1'($urandom);
         ticks(l + 3);
      end
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom % 4 == 0, $urandom % 24 == 0, $urandom % 6 == 0, 1'($urandom),
                int'($urandom % 16), $urandom % 4 != 0);
         tick();
      end
      set_in(0, 0, 0, 0, 0, 0);
      ticks(2);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
